// File: rtl/oq_pkt_dispatcher_pkg.sv
// Shared output-queue definitions: dispatcher state encoding and IOQ module-header
// field positions, also used by the header parser.
package oq_pkt_dispatcher_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_HDR  = 2'd1,
        SEND_DATA = 2'd2
    } oq_state_e;

    localparam logic [7:0] IOQ_STAGE_NUM    = 8'hff;
    localparam int         IOQ_BYTE_LEN_POS = 0;
    localparam int         IOQ_SRC_PORT_POS = 16;
    localparam int         IOQ_WORD_LEN_POS = 32;
    localparam int         IOQ_DST_PORT_POS = 48;

endpackage

// File: rtl/oq_pkt_dispatcher_sat_counter.sv
// Counter with synchronous clear and selectable saturate-or-wrap behaviour.
// Clear and increment together load INCR.
module oq_sat_counter #(
    parameter int WIDTH    = 8,
    parameter int INCR     = 1,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    localparam logic [WIDTH:0] INCR_EXT = (WIDTH+1)'(INCR);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   sum;

    always_comb begin
        base    = clear_i ? '0 : count_q;
        sum     = {1'b0, base} + (inc_i ? INCR_EXT : '0);
        count_d = sum[WIDTH-1:0];
        if (SATURATE && sum[WIDTH]) begin
            count_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/oq_pkt_dispatcher.sv
// Output-queue dispatcher: pops one parsed header per packet, streams the packet's
// words to the selected output queue under backpressure and checks the data length.
module oq_pkt_dispatcher
    import oq_pkt_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH         = 64,
    parameter int CTRL_WIDTH         = DATA_WIDTH/8,
    parameter int NUM_OUTPUT_QUEUES  = 8,
    parameter int NUM_OQ_WIDTH       = $clog2(NUM_OUTPUT_QUEUES),
    parameter int PKT_WORD_CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          dst_oq_avail_i,
    input  logic [NUM_OQ_WIDTH-1:0]       parsed_dst_oq_i,
    input  logic [PKT_WORD_CNT_WIDTH-1:0] parsed_pkt_word_len_i,
    output logic                          rd_dst_oq_o,
    input  logic                          pkt_empty_i,
    input  logic [CTRL_WIDTH-1:0]         pkt_ctrl_i,
    input  logic [DATA_WIDTH-1:0]         pkt_data_i,
    output logic                          pkt_rd_o,
    output logic [NUM_OUTPUT_QUEUES-1:0]  out_wr_o,
    output logic [CTRL_WIDTH-1:0]         out_ctrl_o,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    input  logic [NUM_OUTPUT_QUEUES-1:0]  out_rdy_i,
    output logic                          len_err_o,
    output logic [15:0]                   pkt_cnt_o,
    output logic [7:0]                    len_err_cnt_o
);
    localparam int WCNT_WIDTH = PKT_WORD_CNT_WIDTH + 1;
    localparam logic [NUM_OUTPUT_QUEUES-1:0] ONE_HOT = NUM_OUTPUT_QUEUES'(1);

    oq_state_e                      state_q, state_d;
    logic [NUM_OQ_WIDTH-1:0]        sel_q, sel_d;
    logic [PKT_WORD_CNT_WIDTH-1:0]  exp_len_q, exp_len_d;
    logic [NUM_OUTPUT_QUEUES-1:0]   out_wr_q, out_wr_d;
    logic [CTRL_WIDTH-1:0]          out_ctrl_q, out_ctrl_d;
    logic [DATA_WIDTH-1:0]          out_data_q, out_data_d;
    logic                           len_err_q, len_err_d;
    logic [15:0]                    pkt_cnt_q, pkt_cnt_d;

    logic                           xfer, is_data;
    logic                           wcnt_clear, wcnt_inc, lerr_inc;
    logic [WCNT_WIDTH-1:0]          word_cnt;
    logic [WCNT_WIDTH:0]            final_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            exp_len_q  <= '0;
            out_wr_q   <= '0;
            out_ctrl_q <= '0;
            out_data_q <= '0;
            len_err_q  <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            exp_len_q  <= exp_len_d;
            out_wr_q   <= out_wr_d;
            out_ctrl_q <= out_ctrl_d;
            out_data_q <= out_data_d;
            len_err_q  <= len_err_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    // The EOP word counts as a data word, hence final length is word_cnt + 1.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        exp_len_d   = exp_len_q;
        out_wr_d    = '0;
        out_ctrl_d  = out_ctrl_q;
        out_data_d  = out_data_q;
        len_err_d   = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        rd_dst_oq_o = 1'b0;
        pkt_rd_o    = 1'b0;
        wcnt_clear  = 1'b0;
        wcnt_inc    = 1'b0;
        lerr_inc    = 1'b0;
        xfer        = !pkt_empty_i && out_rdy_i[sel_q];
        is_data     = (pkt_ctrl_i == '0);
        final_len   = {1'b0, word_cnt} + (WCNT_WIDTH+1)'(1);

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (dst_oq_avail_i) begin
                        rd_dst_oq_o = 1'b1;
                        sel_d       = parsed_dst_oq_i;
                        exp_len_d   = parsed_pkt_word_len_i;
                        wcnt_clear  = 1'b1;
                        state_d     = SEND_HDR;
                    end
                end
                SEND_HDR, SEND_DATA: begin
                    if (xfer) begin
                        pkt_rd_o   = 1'b1;
                        out_wr_d   = ONE_HOT << sel_q;
                        out_ctrl_d = pkt_ctrl_i;
                        out_data_d = pkt_data_i;
                        if (state_q == SEND_HDR) begin
                            if (is_data) begin
                                wcnt_clear = 1'b1;
                                wcnt_inc   = 1'b1;
                                state_d    = SEND_DATA;
                            end
                        end else if (is_data) begin
                            wcnt_inc = 1'b1;
                        end else begin
                            if (final_len != {2'b00, exp_len_q}) begin
                                len_err_d = 1'b1;
                                lerr_inc  = 1'b1;
                            end
                            pkt_cnt_d = pkt_cnt_q + 16'd1;
                            state_d   = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    oq_sat_counter #(
        .WIDTH    (WCNT_WIDTH),
        .INCR     (1),
        .SATURATE (1'b1)
    ) u_word_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (wcnt_clear),
        .inc_i   (wcnt_inc),
        .count_o (word_cnt)
    );

    oq_sat_counter #(
        .WIDTH    (8),
        .INCR     (1),
        .SATURATE (1'b1)
    ) u_len_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear_i (1'b0),
        .inc_i   (lerr_inc),
        .count_o (len_err_cnt_o)
    );

    assign out_wr_o   = out_wr_q;
    assign out_ctrl_o = out_ctrl_q;
    assign out_data_o = out_data_q;
    assign len_err_o  = len_err_q;
    assign pkt_cnt_o  = pkt_cnt_q;

endmodule

// File: tb/tb_oq_pkt_dispatcher.sv
// Directed bench for oq_pkt_dispatcher: models the header and packet-word FIFOs as
// queues and compares every output-queue write against the words that were queued.
module tb_oq_pkt_dispatcher;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 8;
    localparam int QW = 3;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dst_oq_avail = 1'b0;
    logic [QW-1:0] parsed_dst_oq = '0;
    logic [LW-1:0] parsed_pkt_word_len = '0;
    logic          rd_dst_oq;
    logic          pkt_empty = 1'b1;
    logic [CW-1:0] pkt_ctrl = '0;
    logic [DW-1:0] pkt_data = '0;
    logic          pkt_rd;
    logic [NQ-1:0] out_wr;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NQ-1:0] out_rdy = '1;
    logic          len_err;
    logic [15:0]   pkt_cnt;
    logic [7:0]    len_err_cnt;

    oq_pkt_dispatcher #(
        .DATA_WIDTH         (DW),
        .CTRL_WIDTH         (CW),
        .NUM_OUTPUT_QUEUES  (NQ),
        .NUM_OQ_WIDTH       (QW),
        .PKT_WORD_CNT_WIDTH (LW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .dst_oq_avail_i        (dst_oq_avail),
        .parsed_dst_oq_i       (parsed_dst_oq),
        .parsed_pkt_word_len_i (parsed_pkt_word_len),
        .rd_dst_oq_o           (rd_dst_oq),
        .pkt_empty_i           (pkt_empty),
        .pkt_ctrl_i            (pkt_ctrl),
        .pkt_data_i            (pkt_data),
        .pkt_rd_o              (pkt_rd),
        .out_wr_o              (out_wr),
        .out_ctrl_o            (out_ctrl),
        .out_data_o            (out_data),
        .out_rdy_i             (out_rdy),
        .len_err_o             (len_err),
        .pkt_cnt_o             (pkt_cnt),
        .len_err_cnt_o         (len_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [QW-1:0] dst; logic [LW-1:0] len; } hdr_t;
    typedef struct { logic [CW-1:0] ctrl; logic [DW-1:0] data; } word_t;
    typedef struct { logic [NQ-1:0] wr; logic [CW-1:0] ctrl; logic [DW-1:0] data; logic lerr; int cyc; } wr_t;

    hdr_t  hdrQ[$];
    word_t wordQ[$];
    wr_t   expQ[$];
    wr_t   logQ[$];

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    int lerrPulses = 0;
    int rdyMode    = 0;
    bit bubbleEn   = 1'b0;
    bit resetReq   = 1'b1;
    logic [NQ-1:0] rdyHist [0:4095];

    logic          obsRdDst, obsPktRd, obsLerr;
    logic [NQ-1:0] obsWr;
    logic [CW-1:0] obsCtrl;
    logic [DW-1:0] obsData;
    logic [15:0]   obsPktCnt;
    logic [7:0]    obsLerrCnt;

    // Every comparison goes through here so the counts stay in one place.
    task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] %s differs", tag);
        end
    endtask

    // One clock: drive FIFO heads at negedge, snapshot outputs, pop on the following posedge.
    task automatic applyStimulus();
        bit hpop;
        bit wpop;
        bit bub;
        @(negedge clk);
        reset = resetReq;
        bub = bubbleEn && (cycle % 4 == 1);
        dst_oq_avail = (hdrQ.size() != 0);
        if (hdrQ.size() != 0) begin
            parsed_dst_oq       = hdrQ[0].dst;
            parsed_pkt_word_len = hdrQ[0].len;
        end else begin
            parsed_dst_oq       = '0;
            parsed_pkt_word_len = '0;
        end
        pkt_empty = (wordQ.size() == 0) || bub;
        if (wordQ.size() != 0) begin
            pkt_ctrl = wordQ[0].ctrl;
            pkt_data = wordQ[0].data;
        end else begin
            pkt_ctrl = '0;
            pkt_data = '0;
        end
        if (rdyMode == 1) out_rdy = ((cycle / 3) % 2 == 0) ? 8'h20 : 8'hDF;
        else              out_rdy = '1;
        if (cycle < 4096) rdyHist[cycle] = out_rdy;
        #1;
        hpop       = rd_dst_oq;
        wpop       = pkt_rd;
        obsRdDst   = rd_dst_oq;
        obsPktRd   = pkt_rd;
        obsWr      = out_wr;
        obsCtrl    = out_ctrl;
        obsData    = out_data;
        obsLerr    = len_err;
        obsPktCnt  = pkt_cnt;
        obsLerrCnt = len_err_cnt;
        if (out_wr != '0) logQ.push_back('{out_wr, out_ctrl, out_data, len_err, cycle});
        if (len_err) lerrPulses++;
        @(posedge clk);
        if (hpop) void'(hdrQ.pop_front());
        if (wpop) void'(wordQ.pop_front());
        cycle++;
    endtask

    task automatic addPkt(input int dst, input int nHdr, input int nData, input int plen, input int id);
        hdrQ.push_back('{QW'(dst), LW'(plen)});
        for (int i = 0; i < nHdr + nData; i++) begin
            word_t w;
            logic  lerr;
            w.data = {16'(id), 16'(i), 32'hC0DE_0000 + 32'(i)};
            if (i < nHdr)                  w.ctrl = 8'hFF;
            else if (i == nHdr + nData - 1) w.ctrl = 8'h80;
            else                           w.ctrl = 8'h00;
            wordQ.push_back(w);
            lerr = (i == nHdr + nData - 1) && (nData != plen);
            expQ.push_back('{8'(1 << dst), w.ctrl, w.data, lerr, 0});
        end
    endtask

    task automatic runUntilDrained(input string tag, input int budget);
        int n = 0;
        while ((hdrQ.size() != 0 || wordQ.size() != 0) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_drained"}, 96'(n < budget), 96'(1));
        repeat (3) applyStimulus();
    endtask

    task automatic compareLog(input string tag, input bit contiguous);
        checkOutput({tag, "_count"}, 96'(logQ.size()), 96'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < logQ.size(); i++) begin
            checkOutput($sformatf("%s_wr%0d", tag, i), 96'(logQ[i].wr), 96'(expQ[i].wr));
            checkOutput($sformatf("%s_word%0d", tag, i), {24'h0, logQ[i].ctrl, logQ[i].data},
                        {24'h0, expQ[i].ctrl, expQ[i].data});
            checkOutput($sformatf("%s_lerr%0d", tag, i), 96'(logQ[i].lerr), 96'(expQ[i].lerr));
            if (contiguous && i > 0)
                checkOutput($sformatf("%s_gap%0d", tag, i), 96'(logQ[i].cyc - logQ[i-1].cyc), 96'(1));
        end
        logQ.delete();
        expQ.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values
        repeat (3) applyStimulus();
        checkOutput("rst_out_wr", 96'(obsWr), 96'(0));
        checkOutput("rst_out_ctrl", 96'(obsCtrl), 96'(0));
        checkOutput("rst_out_data", 96'(obsData), 96'(0));
        checkOutput("rst_len_err", 96'(obsLerr), 96'(0));
        checkOutput("rst_pkt_cnt", 96'(obsPktCnt), 96'(0));
        checkOutput("rst_len_err_cnt", 96'(obsLerrCnt), 96'(0));
        resetReq = 1'b0;
        repeat (2) applyStimulus();

        // Single packet to queue 3: 2 header + 8 data words, back-to-back writes
        addPkt(3, 2, 8, 8, 1);
        runUntilDrained("t1", 100);
        checkOutput("t1_first_wr", 96'(logQ.size() > 0 ? logQ[0].wr : 8'h00), 96'(8'h08));
        compareLog("t1", 1'b1);
        checkOutput("t1_pkt_cnt", 96'(obsPktCnt), 96'(1));
        checkOutput("t1_len_err_cnt", 96'(obsLerrCnt), 96'(0));

        // Back-to-back packets to queues 0 and 7 with exactly one idle cycle between
        addPkt(0, 1, 2, 2, 2);
        addPkt(7, 1, 2, 2, 3);
        runUntilDrained("t2", 100);
        if (logQ.size() == 6) begin
            checkOutput("t2_pktA_span", 96'(logQ[2].cyc - logQ[0].cyc), 96'(2));
            checkOutput("t2_idle_gap", 96'(logQ[3].cyc - logQ[2].cyc), 96'(2));
        end
        compareLog("t2", 1'b0);
        checkOutput("t2_pkt_cnt", 96'(obsPktCnt), 96'(3));

        // Queue 5 backpressure toggling every 3 cycles, other queues inverted
        rdyMode = 1;
        addPkt(5, 1, 8, 8, 4);
        runUntilDrained("t3", 200);
        for (int i = 0; i < logQ.size(); i++)
            checkOutput($sformatf("t3_rdy_before_wr%0d", i), 96'(rdyHist[logQ[i].cyc - 1][5]), 96'(1));
        compareLog("t3", 1'b0);
        checkOutput("t3_pkt_cnt", 96'(obsPktCnt), 96'(4));
        rdyMode = 0;

        // Parsed length 10 with 9 data words: error pulse on EOP, packet still forwarded
        lerrPulses = 0;
        addPkt(1, 1, 9, 10, 5);
        runUntilDrained("t4", 100);
        compareLog("t4", 1'b1);
        checkOutput("t4_len_err_cnt", 96'(obsLerrCnt), 96'(1));
        checkOutput("t4_lerr_pulses", 96'(lerrPulses), 96'(1));
        checkOutput("t4_pkt_cnt", 96'(obsPktCnt), 96'(5));

        // Empty bubbles stall without writes
        bubbleEn = 1'b1;
        addPkt(6, 2, 6, 6, 6);
        runUntilDrained("t5", 200);
        for (int i = 0; i < logQ.size(); i++)
            checkOutput($sformatf("t5_no_wr_after_bubble%0d", i), 96'((logQ[i].cyc - 1) % 4 == 1), 96'(0));
        compareLog("t5", 1'b0);
        checkOutput("t5_pkt_cnt", 96'(obsPktCnt), 96'(6));
        bubbleEn = 1'b0;

        // Reset in the middle of a packet, with another header waiting
        addPkt(1, 1, 6, 6, 7);
        addPkt(4, 1, 2, 2, 8);
        repeat (4) applyStimulus();
        resetReq = 1'b1;
        applyStimulus();
        checkOutput("t5r_pkt_rd_in_reset", 96'(obsPktRd), 96'(0));
        applyStimulus();
        checkOutput("t5r_rd_dst_in_reset", 96'(obsRdDst), 96'(0));
        checkOutput("t5r_out_wr", 96'(obsWr), 96'(0));
        checkOutput("t5r_out_ctrl", 96'(obsCtrl), 96'(0));
        checkOutput("t5r_out_data", 96'(obsData), 96'(0));
        checkOutput("t5r_len_err", 96'(obsLerr), 96'(0));
        checkOutput("t5r_pkt_cnt", 96'(obsPktCnt), 96'(0));
        checkOutput("t5r_len_err_cnt", 96'(obsLerrCnt), 96'(0));
        hdrQ.delete();
        wordQ.delete();
        logQ.delete();
        expQ.delete();
        resetReq = 1'b0;
        applyStimulus();
        addPkt(2, 1, 3, 3, 9);
        runUntilDrained("t5c", 100);
        compareLog("t5c", 1'b1);
        checkOutput("t5c_pkt_cnt", 96'(obsPktCnt), 96'(1));

        // 300 mismatched packets: error counter saturates, packet counter keeps going
        lerrPulses = 0;
        for (int k = 0; k < 255; k++) addPkt(0, 0, 2, 5, 100 + k);
        runUntilDrained("t6a", 2000);
        compareLog("t6a", 1'b0);
        checkOutput("t6a_len_err_cnt", 96'(obsLerrCnt), 96'(255));
        checkOutput("t6a_pkt_cnt", 96'(obsPktCnt), 96'(256));
        for (int k = 0; k < 45; k++) addPkt(0, 0, 2, 5, 400 + k);
        runUntilDrained("t6b", 500);
        compareLog("t6b", 1'b0);
        checkOutput("t6b_len_err_cnt", 96'(obsLerrCnt), 96'(255));
        checkOutput("t6b_pkt_cnt", 96'(obsPktCnt), 96'(301));
        checkOutput("t6b_lerr_pulses", 96'(lerrPulses), 96'(300));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
